// File: rtl/axi_pkg.sv
// Shared AXI4-Lite constants, response codes and the initiator state type
// used by the core-side bridge.
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } axi_mst_state_t;

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_master_bridge.sv
// Core-side AXI4-Lite initiator: turns one single-beat core request into an
// AR/R or AW+W/B transaction and reports data, error flag and a done pulse.
module axi_master_bridge
    import axi_pkg::*;
(
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [AXI_ADDR_BITS-1:0] addr_i,
    input  logic [AXI_STRB_BITS-1:0] wstrb_i,
    input  logic [AXI_DATA_BITS-1:0] wdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [AXI_DATA_BITS-1:0] rdata_o,
    output logic                     err_o,
    output logic [AXI_ADDR_BITS-1:0] ARADDR_M,
    output logic                     ARVALID_M,
    input  logic                     ARREADY_M,
    input  logic [AXI_DATA_BITS-1:0] RDATA_M,
    input  logic [1:0]               RRESP_M,
    input  logic                     RVALID_M,
    output logic                     RREADY_M,
    output logic [AXI_ADDR_BITS-1:0] AWADDR_M,
    output logic                     AWVALID_M,
    input  logic                     AWREADY_M,
    output logic [AXI_DATA_BITS-1:0] WDATA_M,
    output logic [AXI_STRB_BITS-1:0] WSTRB_M,
    output logic                     WVALID_M,
    input  logic                     WREADY_M,
    input  logic [1:0]               BRESP_M,
    input  logic                     BVALID_M,
    output logic                     BREADY_M
);

    axi_mst_state_t state_r;
    logic           aw_done_r;
    logic           w_done_r;

    logic ar_hs_s;
    logic r_hs_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic aw_fin_s;
    logic w_fin_s;

    // Handshakes are qualified by our own registered VALID/READY, so a
    // RVALID/BVALID arriving while READY is low is never captured.
    assign ar_hs_s  = ARVALID_M & ARREADY_M;
    assign r_hs_s   = RREADY_M  & RVALID_M;
    assign aw_hs_s  = AWVALID_M & AWREADY_M;
    assign w_hs_s   = WVALID_M  & WREADY_M;
    assign b_hs_s   = BREADY_M  & BVALID_M;
    assign aw_fin_s = aw_done_r | aw_hs_s;
    assign w_fin_s  = w_done_r  | w_hs_s;

    // Transaction FSM; every core-side and AXI output is a register here.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r   <= ST_IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rdata_o   <= {AXI_DATA_BITS{1'b0}};
            err_o     <= 1'b0;
            ARADDR_M  <= {AXI_ADDR_BITS{1'b0}};
            ARVALID_M <= 1'b0;
            RREADY_M  <= 1'b0;
            AWADDR_M  <= {AXI_ADDR_BITS{1'b0}};
            AWVALID_M <= 1'b0;
            WDATA_M   <= {AXI_DATA_BITS{1'b0}};
            WSTRB_M   <= {AXI_STRB_BITS{1'b0}};
            WVALID_M  <= 1'b0;
            BREADY_M  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_i) begin
                        busy_o <= 1'b1;
                        if (we_i) begin
                            AWADDR_M  <= addr_i;
                            WDATA_M   <= wdata_i;
                            WSTRB_M   <= wstrb_i;
                            AWVALID_M <= 1'b1;
                            WVALID_M  <= 1'b1;
                            state_r   <= ST_WR_REQ;
                        end else begin
                            ARADDR_M  <= addr_i;
                            ARVALID_M <= 1'b1;
                            state_r   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_hs_s) begin
                        ARVALID_M <= 1'b0;
                        RREADY_M  <= 1'b1;
                        state_r   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs_s) begin
                        RREADY_M <= 1'b0;
                        rdata_o  <= RDATA_M;
                        err_o    <= resp_is_err(RRESP_M);
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W retire independently; B waits for both.
                    if (aw_hs_s) begin
                        AWVALID_M <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        WVALID_M <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        BREADY_M  <= 1'b1;
                        state_r   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs_s) begin
                        BREADY_M <= 1'b0;
                        err_o    <= resp_is_err(BRESP_M);
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    busy_o    <= 1'b0;
                    ARVALID_M <= 1'b0;
                    RREADY_M  <= 1'b0;
                    AWVALID_M <= 1'b0;
                    WVALID_M  <= 1'b0;
                    BREADY_M  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge: directed scenarios with literal
// expectations, then randomized traffic against a channel-level model.
module tb_axi_master_bridge;
    import axi_pkg::*;

    logic        ACLK;
    logic        ARESETn;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic [31:0] ARADDR_M, AWADDR_M, WDATA_M, RDATA_M;
    logic        ARVALID_M, ARREADY_M, RVALID_M, RREADY_M;
    logic        AWVALID_M, AWREADY_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;
    logic [1:0]  RRESP_M, BRESP_M;
    logic [3:0]  WSTRB_M;

    axi_master_bridge dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wstrb_i(wstrb_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .ARADDR_M(ARADDR_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit manual = 1'b1;
    int rwait = 0;
    int bwait = 0;

    // Model of what the current cycle's outputs must be.
    bit          m_busy, m_done, m_err;
    bit          m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [31:0] m_rdata, m_araddr, m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0;
        m_arvalid = 0; m_rready = 0; m_awvalid = 0; m_wvalid = 0; m_bready = 0;
        m_rdata = 32'h0; m_araddr = 32'h0; m_awaddr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
    endtask

    task automatic compare_all();
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
        chk("done", {31'd0, done_o}, {31'd0, m_done});
        chk("err", {31'd0, err_o}, {31'd0, m_err});
        chk("rdata", rdata_o, m_rdata);
        chk("arvalid", {31'd0, ARVALID_M}, {31'd0, m_arvalid});
        chk("araddr", ARADDR_M, m_araddr);
        chk("rready", {31'd0, RREADY_M}, {31'd0, m_rready});
        chk("awvalid", {31'd0, AWVALID_M}, {31'd0, m_awvalid});
        chk("awaddr", AWADDR_M, m_awaddr);
        chk("wvalid", {31'd0, WVALID_M}, {31'd0, m_wvalid});
        chk("wdata", WDATA_M, m_wdata);
        chk("wstrb", {28'd0, WSTRB_M}, {28'd0, m_wstrb});
        chk("bready", {31'd0, BREADY_M}, {31'd0, m_bready});
    endtask

    // Predict next cycle's outputs from this cycle's outputs and the inputs now driven.
    task automatic model_update();
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, in_wr;
        if (!ARESETn) begin
            model_reset();
            return;
        end
        ar_hs = m_arvalid && ARREADY_M;
        r_hs  = m_rready && RVALID_M;
        aw_hs = m_awvalid && AWREADY_M;
        w_hs  = m_wvalid && WREADY_M;
        b_hs  = m_bready && BVALID_M;
        in_wr = m_awvalid || m_wvalid;
        m_done = 0;
        if (!m_busy) begin
            if (req_i) begin
                m_busy = 1;
                if (we_i) begin
                    m_awvalid = 1; m_wvalid = 1;
                    m_awaddr = addr_i; m_wdata = wdata_i; m_wstrb = wstrb_i;
                end else begin
                    m_arvalid = 1; m_araddr = addr_i;
                end
            end
        end else begin
            if (ar_hs) begin
                m_arvalid = 0; m_rready = 1; rwait = $urandom_range(0, 3);
            end
            if (r_hs) begin
                m_rready = 0; m_busy = 0; m_done = 1;
                m_rdata = RDATA_M; m_err = (RRESP_M != 2'b00);
            end
            if (aw_hs) m_awvalid = 0;
            if (w_hs) m_wvalid = 0;
            if (in_wr && !m_awvalid && !m_wvalid) begin
                m_bready = 1; bwait = $urandom_range(0, 3);
            end
            if (b_hs) begin
                m_bready = 0; m_busy = 0; m_done = 1; m_err = (BRESP_M != 2'b00);
            end
        end
    endtask

    task automatic random_drive();
        ARESETn   = ($urandom_range(0, 299) != 0);
        req_i     = ($urandom_range(0, 99) < 60);
        we_i      = $urandom_range(0, 1);
        addr_i    = $urandom;
        wdata_i   = $urandom;
        wstrb_i   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        ARREADY_M = $urandom_range(0, 1);
        AWREADY_M = $urandom_range(0, 1);
        WREADY_M  = $urandom_range(0, 1);
        RDATA_M   = $urandom;
        RRESP_M   = 2'($urandom_range(0, 3));
        BRESP_M   = 2'($urandom_range(0, 3));
        RVALID_M  = 1'b0;
        BVALID_M  = 1'b0;
        if (m_rready) begin
            if (rwait == 0) RVALID_M = 1'b1;
            else rwait--;
        end else if ($urandom_range(0, 9) == 0) RVALID_M = 1'b1;
        if (m_bready) begin
            if (bwait == 0) BVALID_M = 1'b1;
            else bwait--;
        end else if ($urandom_range(0, 9) == 0) BVALID_M = 1'b1;
    endtask

    task automatic step();
        compare_all();
        if (!manual) random_drive();
        model_update();
        @(negedge ACLK);
    endtask

    task automatic idle_inputs();
        req_i = 0; we_i = 0; addr_i = 32'h0; wdata_i = 32'h0; wstrb_i = 4'h0;
        ARREADY_M = 0; RVALID_M = 0; RDATA_M = 32'h0; RRESP_M = 2'b00;
        AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = 2'b00;
    endtask

    task automatic request(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_i = 1; we_i = we; addr_i = a; wdata_i = d; wstrb_i = s;
    endtask

    initial begin
        ARESETn = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge ACLK);
        chk("lit_rst_arvalid", {31'd0, ARVALID_M}, 32'd0);
        chk("lit_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("lit_rst_rdata", rdata_o, 32'h0);
        chk("lit_rst_awaddr", AWADDR_M, 32'h0);
        ARESETn = 1;
        step();

        // Read, zero-wait slave
        request(0, 32'h0000_0010, 32'h0, 4'h0); step();
        chk("lit_rd_arvalid", {31'd0, ARVALID_M}, 32'd1);
        chk("lit_rd_araddr", ARADDR_M, 32'h0000_0010);
        req_i = 0; ARREADY_M = 1; step();
        chk("lit_rd_rready", {31'd0, RREADY_M}, 32'd1);
        ARREADY_M = 0; RVALID_M = 1; RDATA_M = 32'hDEAD_BEEF; RRESP_M = 2'b00; step();
        chk("lit_rd_done", {31'd0, done_o}, 32'd1);
        chk("lit_rd_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("lit_rd_err", {31'd0, err_o}, 32'd0);
        idle_inputs(); step();
        chk("lit_rd_done_pulse", {31'd0, done_o}, 32'd0);

        // Write, AW accepted c1, W delayed to c4
        request(1, 32'h0000_0020, 32'h1234_5678, 4'b0011); step();
        chk("lit_wr_awvalid", {31'd0, AWVALID_M}, 32'd1);
        chk("lit_wr_wvalid", {31'd0, WVALID_M}, 32'd1);
        req_i = 0; AWREADY_M = 1; step();
        chk("lit_wr_awdrop", {31'd0, AWVALID_M}, 32'd0);
        AWREADY_M = 0; step();
        chk("lit_wr_wdata", WDATA_M, 32'h1234_5678);
        step();
        chk("lit_wr_wstrb", {28'd0, WSTRB_M}, 32'h3);
        chk("lit_wr_bready_early", {31'd0, BREADY_M}, 32'd0);
        WREADY_M = 1; step();
        chk("lit_wr_bready", {31'd0, BREADY_M}, 32'd1);
        WREADY_M = 0; step();
        BVALID_M = 1; BRESP_M = 2'b00; step();
        chk("lit_wr_done", {31'd0, done_o}, 32'd1);
        chk("lit_wr_rdata_kept", rdata_o, 32'hDEAD_BEEF);
        idle_inputs(); step();

        // ARREADY held low 5 cycles, ignored req pulses, SLVERR, back-to-back write
        request(0, 32'h0000_0100, 32'h0, 4'h0); step();
        for (int i = 0; i < 5; i++) begin
            chk("lit_stall_araddr", ARADDR_M, 32'h0000_0100);
            chk("lit_stall_busy", {31'd0, busy_o}, 32'd1);
            request(1, 32'hFFFF_FFFC, 32'h0, 4'hF);
            req_i = i[0];
            step();
        end
        chk("lit_stall_arvalid", {31'd0, ARVALID_M}, 32'd1);
        req_i = 0; ARREADY_M = 1; step();
        ARREADY_M = 0; RVALID_M = 1; RDATA_M = 32'h5555_AAAA; RRESP_M = 2'b10;
        request(1, 32'h0000_0030, 32'hA5A5_A5A5, 4'h0); step();
        chk("lit_slverr_err", {31'd0, err_o}, 32'd1);
        chk("lit_slverr_done", {31'd0, done_o}, 32'd1);
        RVALID_M = 0; step();
        chk("lit_b2b_awvalid", {31'd0, AWVALID_M}, 32'd1);
        chk("lit_b2b_awaddr", AWADDR_M, 32'h0000_0030);
        req_i = 0; AWREADY_M = 1; WREADY_M = 1; step();
        AWREADY_M = 0; WREADY_M = 0; BVALID_M = 1; BRESP_M = 2'b00; step();
        chk("lit_okay_err", {31'd0, err_o}, 32'd0);
        chk("lit_okay_rdata", rdata_o, 32'h5555_AAAA);
        idle_inputs(); step();

        // Reset with AW done and W pending, then a normal read
        request(1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF); step();
        req_i = 0; AWREADY_M = 1; step();
        chk("lit_mid_wvalid", {31'd0, WVALID_M}, 32'd1);
        AWREADY_M = 0; ARESETn = 0; step();
        chk("lit_mrst_wvalid", {31'd0, WVALID_M}, 32'd0);
        chk("lit_mrst_busy", {31'd0, busy_o}, 32'd0);
        chk("lit_mrst_wdata", WDATA_M, 32'h0);
        ARESETn = 1; request(0, 32'h0000_0044, 32'h0, 4'h0); step();
        req_i = 0; ARREADY_M = 1; step();
        ARREADY_M = 0; RVALID_M = 1; RDATA_M = 32'hCAFE_F00D; RRESP_M = 2'b00; step();
        chk("lit_post_rdata", rdata_o, 32'hCAFE_F00D);
        idle_inputs(); step();

        // Randomized traffic
        manual = 1'b0;
        for (int i = 0; i < 4000; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
